// File: rtl/tcp_tx_ctrl.sv
// tcp_tx_ctrl: sequences one flow at a time. It takes a flow from the
// scheduler, reads the flow state, then runs the calc and sched steps.
// Finally it completes the packet, next-state write and scheduler update
// hand-offs.
//
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   sched_tx_req_val / tx_sched_req_rdy      scheduler request handshake
//   ctrl_datap_store_*        single-cycle load strobes to the datapath
//   state_rd_req_val / _rdy   state memory read request
//   datap_ctrl_produce_pkt    datapath says a packet is needed
//   tx_pkt_val / _rdy         packet descriptor hand-off
//   next_tx_state_wr_req_val / _rdy          next-tx-state write
//   tx_sched_update_val / sched_tx_update_rdy  scheduler update
//   stat_pkt_cnt, stat_empty_cnt  only when TCP_TX_CTRL_STATS_EN is defined
//
// Parameter RD_LATENCY (1..15): cycles from an accepted read to valid data.
module tcp_tx_ctrl #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sched_tx_req_val,
    output logic        tx_sched_req_rdy,
    output logic        ctrl_datap_store_flowid,
    output logic        ctrl_datap_store_state,
    output logic        ctrl_datap_store_calc,
    output logic        ctrl_datap_store_tuple,
    output logic        ctrl_datap_store_sched,
    output logic        state_rd_req_val,
    input  logic        state_rd_req_rdy,
    input  logic        datap_ctrl_produce_pkt,
    output logic        tx_pkt_val,
    input  logic        tx_pkt_rdy,
    output logic        next_tx_state_wr_req_val,
    input  logic        next_tx_state_wr_req_rdy,
    output logic        tx_sched_update_val,
`ifdef TCP_TX_CTRL_STATS_EN
    output logic [31:0] stat_pkt_cnt,
    output logic [31:0] stat_empty_cnt,
`endif
    input  logic        sched_tx_update_rdy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_CALC    = 3'd3;
    localparam logic [2:0] S_SCHED   = 3'd4;
    localparam logic [2:0] S_OUT     = 3'd5;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       need_q, need_d;
    logic       first_q, first_d;   // marks the first OUT cycle
    logic       pkt_done_q, pkt_done_d;
    logic       wr_done_q, wr_done_d;
    logic       upd_done_q, upd_done_d;
    logic       need_eff;

    // produce_pkt is only meaningful in the first OUT cycle, so it is used
    // directly there and from the captured copy afterwards.
    assign need_eff = first_q ? datap_ctrl_produce_pkt : need_q;

    always_comb begin
        state_d                  = state_q;
        cnt_d                    = cnt_q;
        need_d                   = need_q;
        first_d                  = first_q;
        pkt_done_d               = pkt_done_q;
        wr_done_d                = wr_done_q;
        upd_done_d               = upd_done_q;
        tx_sched_req_rdy         = 1'b0;
        ctrl_datap_store_flowid  = 1'b0;
        ctrl_datap_store_state   = 1'b0;
        ctrl_datap_store_calc    = 1'b0;
        ctrl_datap_store_tuple   = 1'b0;
        ctrl_datap_store_sched   = 1'b0;
        state_rd_req_val         = 1'b0;
        tx_pkt_val               = 1'b0;
        next_tx_state_wr_req_val = 1'b0;
        tx_sched_update_val      = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_sched_req_rdy = 1'b1;
                // rdy shows 1 during reset, but nothing may be accepted then.
                if (sched_tx_req_val && rst) begin
                    ctrl_datap_store_flowid = 1'b1;
                    state_d                 = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                state_rd_req_val = 1'b1;
                if (state_rd_req_rdy) begin
                    cnt_d   = 4'(RD_LATENCY - 1);
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    ctrl_datap_store_state = 1'b1;
                    ctrl_datap_store_tuple = 1'b1;
                    state_d                = S_CALC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CALC: begin
                ctrl_datap_store_calc = 1'b1;
                state_d               = S_SCHED;
            end
            S_SCHED: begin
                ctrl_datap_store_sched = 1'b1;
                pkt_done_d             = 1'b0;
                wr_done_d              = 1'b0;
                upd_done_d             = 1'b0;
                first_d                = 1'b1;
                state_d                = S_OUT;
            end
            S_OUT: begin
                first_d                  = 1'b0;
                if (first_q) need_d      = datap_ctrl_produce_pkt;
                tx_pkt_val               = need_eff & ~pkt_done_q;
                next_tx_state_wr_req_val = ~wr_done_q;
                tx_sched_update_val      = ~upd_done_q;
                pkt_done_d = pkt_done_q | ~need_eff | (tx_pkt_val & tx_pkt_rdy);
                wr_done_d  = wr_done_q | next_tx_state_wr_req_rdy;
                upd_done_d = upd_done_q | sched_tx_update_rdy;
                // Leave as soon as the last handshake lands, so IDLE is
                // the very next cycle.
                if (pkt_done_d && wr_done_d && upd_done_d) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            need_q     <= 1'b0;
            first_q    <= 1'b0;
            pkt_done_q <= 1'b0;
            wr_done_q  <= 1'b0;
            upd_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            need_q     <= need_d;
            first_q    <= first_d;
            pkt_done_q <= pkt_done_d;
            wr_done_q  <= wr_done_d;
            upd_done_q <= upd_done_d;
        end
    end

`ifdef TCP_TX_CTRL_STATS_EN
    logic [31:0] pkt_cnt_q, empty_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_q   <= 32'd0;
            empty_cnt_q <= 32'd0;
        end else begin
            if (tx_pkt_val && tx_pkt_rdy) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (state_q == S_OUT && first_q && !datap_ctrl_produce_pkt)
                empty_cnt_q <= empty_cnt_q + 32'd1;
        end
    end

    assign stat_pkt_cnt   = pkt_cnt_q;
    assign stat_empty_cnt = empty_cnt_q;
`endif

endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// Bench for tcp_tx_ctrl: two instances (RD_LATENCY 1 and 3) share stimulus.
// A flow-timeline model predicts every output each cycle. Directed
// literal checks pin the model to the documented timelines.
module tb_tcp_tx_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic val, rd_rdy, produce, pkt_rdy, wr_rdy, upd_rdy;
    logic [1:0] rr, fl, st, ca, tu, sc, rdv, pv, wv, uv;
    logic [31:0] pc [2];
    logic [31:0] ec [2];

    int checks = 0;
    int failures = 0;

    tcp_tx_ctrl #(.RD_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .sched_tx_req_val(val), .tx_sched_req_rdy(rr[0]),
        .ctrl_datap_store_flowid(fl[0]), .ctrl_datap_store_state(st[0]),
        .ctrl_datap_store_calc(ca[0]), .ctrl_datap_store_tuple(tu[0]),
        .ctrl_datap_store_sched(sc[0]), .state_rd_req_val(rdv[0]),
        .state_rd_req_rdy(rd_rdy), .datap_ctrl_produce_pkt(produce),
        .tx_pkt_val(pv[0]), .tx_pkt_rdy(pkt_rdy),
        .next_tx_state_wr_req_val(wv[0]), .next_tx_state_wr_req_rdy(wr_rdy),
        .tx_sched_update_val(uv[0]),
`ifdef TCP_TX_CTRL_STATS_EN
        .stat_pkt_cnt(pc[0]), .stat_empty_cnt(ec[0]),
`endif
        .sched_tx_update_rdy(upd_rdy));

    tcp_tx_ctrl #(.RD_LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .sched_tx_req_val(val), .tx_sched_req_rdy(rr[1]),
        .ctrl_datap_store_flowid(fl[1]), .ctrl_datap_store_state(st[1]),
        .ctrl_datap_store_calc(ca[1]), .ctrl_datap_store_tuple(tu[1]),
        .ctrl_datap_store_sched(sc[1]), .state_rd_req_val(rdv[1]),
        .state_rd_req_rdy(rd_rdy), .datap_ctrl_produce_pkt(produce),
        .tx_pkt_val(pv[1]), .tx_pkt_rdy(pkt_rdy),
        .next_tx_state_wr_req_val(wv[1]), .next_tx_state_wr_req_rdy(wr_rdy),
        .tx_sched_update_val(uv[1]),
`ifdef TCP_TX_CTRL_STATS_EN
        .stat_pkt_cnt(pc[1]), .stat_empty_cnt(ec[1]),
`endif
        .sched_tx_update_rdy(upd_rdy));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: a flow is busy from acceptance until all hand-offs complete.
    // Once the read is accepted at cycle acc, the strobes land at fixed
    // offsets acc+L, acc+L+1 and acc+L+2. The output phase follows.
    bit busy [2], rdp [2], outb [2], first [2], need [2], pkd [2], wrd [2], upd [2];
    int acc [2];
    int mpc [2], mec [2];
    int cyc = 0;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int k, L;
            bit ne, e_pv, e_wv, e_uv;
            if (!rst) begin
                busy[i] = 0; rdp[i] = 0; outb[i] = 0; first[i] = 0; need[i] = 0;
                pkd[i] = 0; wrd[i] = 0; upd[i] = 0; acc[i] = -1; mpc[i] = 0; mec[i] = 0;
            end
            L = lat(i);
            k = (acc[i] >= 0) ? cyc - acc[i] : -1;
            ne = first[i] ? produce : need[i];
            e_pv = outb[i] & ne & !pkd[i];
            e_wv = outb[i] & !wrd[i];
            e_uv = outb[i] & !upd[i];
            chk($sformatf("d%0d req_rdy @%0d", i, cyc), rr[i], !busy[i]);
            chk($sformatf("d%0d flowid @%0d", i, cyc), fl[i], !busy[i] & val & rst);
            chk($sformatf("d%0d rd_val @%0d", i, cyc), rdv[i], busy[i] & rdp[i]);
            chk($sformatf("d%0d state @%0d", i, cyc), st[i], k == L);
            chk($sformatf("d%0d tuple @%0d", i, cyc), tu[i], k == L);
            chk($sformatf("d%0d calc @%0d", i, cyc), ca[i], k == L + 1);
            chk($sformatf("d%0d sched @%0d", i, cyc), sc[i], k == L + 2);
            chk($sformatf("d%0d pkt_val @%0d", i, cyc), pv[i], e_pv);
            chk($sformatf("d%0d wr_val @%0d", i, cyc), wv[i], e_wv);
            chk($sformatf("d%0d upd_val @%0d", i, cyc), uv[i], e_uv);
`ifdef TCP_TX_CTRL_STATS_EN
            chk($sformatf("d%0d pkt_cnt @%0d", i, cyc), int'(pc[i]), mpc[i]);
            chk($sformatf("d%0d empty_cnt @%0d", i, cyc), int'(ec[i]), mec[i]);
`endif
            if (rst) begin
                if (!busy[i] && val) begin
                    busy[i] = 1; rdp[i] = 1;
                end else if (rdp[i] && rd_rdy) begin
                    rdp[i] = 0; acc[i] = cyc;
                end else if (k == L + 2) begin
                    acc[i] = -1; outb[i] = 1; first[i] = 1; pkd[i] = 0; wrd[i] = 0; upd[i] = 0;
                end else if (outb[i]) begin
                    if (first[i]) begin
                        need[i] = produce;
                        if (!produce) begin pkd[i] = 1; mec[i]++; end
                    end
                    first[i] = 0;
                    if (e_pv && pkt_rdy) begin pkd[i] = 1; mpc[i]++; end
                    if (wr_rdy) wrd[i] = 1;
                    if (upd_rdy) upd[i] = 1;
                    if (pkd[i] && wrd[i] && upd[i]) begin outb[i] = 0; busy[i] = 0; end
                end
            end
        end
        cyc++;
    end

    task automatic wait_idle();
        int n = 0;
        while (!(rr[0] && rr[1]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle reached in budget", int'(n < 100), 1);
    endtask

    // Single request on the RD_LATENCY=1 instance, all rdy high.
    task automatic run_basic();
        @(posedge clk); #1 val = 1;
        @(negedge clk); chk("c0 flowid", fl[0], 1);
        @(posedge clk); #1 val = 0;
        @(negedge clk); chk("c1 rd_val", rdv[0], 1);
        @(negedge clk); chk("c2 store_state", st[0], 1); chk("c2 store_tuple", tu[0], 1);
        @(negedge clk); chk("c3 store_calc", ca[0], 1);
        @(negedge clk); chk("c4 store_sched", sc[0], 1);
        @(negedge clk); chk("c5 pkt_val", pv[0], 1); chk("c5 wr_val", wv[0], 1);
                        chk("c5 upd_val", uv[0], 1);
        @(negedge clk); chk("c6 req_rdy", rr[0], 1);
        wait_idle();
    endtask

    initial begin
        int seen, n;
        val = 0; rd_rdy = 1; produce = 1; pkt_rdy = 1; wr_rdy = 1; upd_rdy = 1;
        // Reset values, including a request offered during reset.
        repeat (2) @(negedge clk);
        chk("reset req_rdy", rr[0], 1);
        chk("reset rd_val", rdv[0], 0);
        @(posedge clk); #1 val = 1;
        @(negedge clk); chk("reset no flowid l1", fl[0], 0); chk("reset no flowid l3", fl[1], 0);
        @(posedge clk); #1 val = 0; rst = 1;
        @(negedge clk);

        run_basic();

        // Read stall of 4 cycles on the RD_LATENCY=3 instance.
        @(posedge clk); #1 val = 1; rd_rdy = 0;
        @(negedge clk); chk("stall flowid", fl[1], 1);
        @(posedge clk); #1 val = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) begin @(posedge clk); #1; end
            if (i == 5) rd_rdy = 1;
            @(negedge clk); chk($sformatf("stall rd_val c%0d", i), rdv[1], 1);
        end
        @(negedge clk); chk("stall rd_val dropped", rdv[1], 0); chk("stall no state c6", st[1], 0);
        @(negedge clk); chk("stall no state c7", st[1], 0);
        @(negedge clk); chk("stall state c8", st[1], 1); chk("stall tuple c8", tu[1], 1);
        wait_idle();

        // No packet needed.
        produce = 0;
        @(posedge clk); #1 val = 1;
        @(posedge clk); #1 val = 0;
        seen = 0;
        repeat (12) begin @(negedge clk); seen += int'(pv[0] | pv[1]); end
        chk("empty no pkt_val", seen, 0);
        wait_idle();
`ifdef TCP_TX_CTRL_STATS_EN
        chk("empty cnt l1", int'(ec[0]), 1);
        chk("empty cnt l3", int'(ec[1]), 1);
`endif
        @(posedge clk); #1 produce = 1;

        // Staggered OUT hand-offs on the RD_LATENCY=1 instance.
        pkt_rdy = 0; wr_rdy = 0; upd_rdy = 0;
        @(posedge clk); #1 val = 1;
        @(posedge clk); #1 val = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!sc[0] && n < 20);
        chk("sched seen", sc[0], 1);
        for (int o = 0; o <= 8; o++) begin
            @(posedge clk); #1;
            upd_rdy = (o == 1); wr_rdy = (o == 3); pkt_rdy = (o == 7);
            @(negedge clk);
            chk($sformatf("out upd_val o%0d", o), uv[0], int'(o <= 1));
            chk($sformatf("out wr_val o%0d", o), wv[0], int'(o <= 3));
            chk($sformatf("out pkt_val o%0d", o), pv[0], int'(o <= 7));
            chk($sformatf("out req_rdy o%0d", o), rr[0], int'(o == 8));
        end
        @(posedge clk); #1 pkt_rdy = 1; wr_rdy = 1; upd_rdy = 1;
        wait_idle();

        // Reset while the RD_LATENCY=3 instance sits in RD_WAIT.
        @(posedge clk); #1 val = 1;
        @(posedge clk); #1 val = 0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk); chk("mid reset req_rdy", rr[1], 1); chk("mid reset state", st[1], 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1;
        seen = 0;
        repeat (4) begin @(negedge clk); seen += int'(st[1]); end
        chk("no state after reset", seen, 0);
        chk("idle after reset", int'(rr[0] & rr[1]), 1);
        run_basic();

        // Back-to-back requests with val held high.
        @(posedge clk); #1 val = 1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("b2b flowid c%0d", c), fl[0], int'(c % 6 == 0));
            chk($sformatf("b2b excl c%0d", c), int'(fl[0] + st[0] + ca[0] + sc[0] <= 1), 1);
        end
        @(posedge clk); #1 val = 0;
        wait_idle();
`ifdef TCP_TX_CTRL_STATS_EN
        chk("final pkt cnt l1", int'(pc[0]), 4);
        chk("final pkt cnt l3", int'(pc[1]), 3);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
